// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared debounce state encoding and default 125 MHz timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  typedef enum logic {
    BTN_LOW  = 1'b0,
    BTN_HIGH = 1'b1
  } btn_state_e;

  // 62500 cycles at 125 MHz gives a 0.5 ms sample tick
  localparam int DEF_N_CH           = 4;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_SAMPLE_CNT_MAX = 62500;
  localparam int DEF_PULSE_CNT_MAX  = 10;
  localparam int DEF_HOLD_TICKS     = 1000;
  localparam int DEF_REPEAT_TICKS   = 200;

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// Module      : btn_channel
// Description : One button lane: synchronizer, two-way debounce, edge pulses,
//               optional auto-repeat (BTN_AUTO_REPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int PULSE_CNT_MAX = DEF_PULSE_CNT_MAX
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rep
);

  localparam int CNT_W = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;
  logic                   level_now;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign level_now = (state_q == BTN_HIGH);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync_out != level_now) begin
        if (cnt_inc == CNT_LAST) begin
          state_d = level_now ? BTN_LOW : BTN_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
    // Edges are taken from the registered level, so they trail it by a cycle
    prev_d = level_now;
    rise_d = level_now & ~prev_q;
    fall_d = ~level_now & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= BTN_LOW;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_now;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              rep_q, rep_d;

  assign hold_inc = hold_q + HOLD_W'(1);

  always_comb begin
    hold_d = hold_q;
    rep_d  = 1'b0;
    if (!level_now) begin
      hold_d = '0;
    end else if (tick) begin
      // Reload instead of wrapping so repeats keep coming while held
      if (hold_inc == HOLD_LAST) begin
        rep_d  = 1'b1;
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign rep = rep_q;
`else
  assign rep = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : N-channel push-button front end with a shared sample tick.
//               Optional auto-repeat enabled by BTN_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_rep
);

  localparam int TICK_W = $clog2(SAMPLE_CNT_MAX);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);

  if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS) begin : g_param_check
    $error("button_conditioner: illegal parameter combination");
  end

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .PULSE_CNT_MAX (PULSE_CNT_MAX)
`ifdef BTN_AUTO_REPEAT_EN
      ,
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
`endif
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .btn_raw (btn_in[i]),
      .level   (btn_level[i]),
      .rise    (btn_rise[i]),
      .fall    (btn_fall[i]),
      .rep     (btn_rep[i])
    );
  end

endmodule

`default_nettype wire
